// File: rtl/gled_pkg.sv
// Green-LED word layout shared by the LSU LED buffer, software header and
// the PWM controller. Field order in gled_word_t matches bit order [31:0].
package gled_pkg;

  localparam int unsigned GLED_WORD_W     = 32;
  localparam int unsigned GLED_NUM_LEDS   = 8;

  localparam int unsigned GLED_ON_LSB     = 0;
  localparam int unsigned GLED_BLINK_LSB  = 8;
  localparam int unsigned GLED_DUTY_LSB   = 16;
  localparam int unsigned GLED_SEL_LSB    = 24;
  localparam int unsigned GLED_RSVD_LSB   = 26;
  localparam int unsigned GLED_BYPASS_BIT = 31;

  typedef struct packed {
    logic       bypass;     // [31]
    logic [4:0] reserved;   // [30:26]
    logic [1:0] blink_sel;  // [25:24]
    logic [7:0] duty;       // [23:16]
    logic [7:0] blink;      // [15:8]
    logic [7:0] on;         // [7:0]
  } gled_word_t;

endpackage

// File: rtl/gled_timebase.sv
// PWM and frame timebase for the green-LED controller.
//   clk_i, rst_ni   : clock, async active-low reset
//   pwm_cnt_o       : free-running PWM counter
//   frame_cnt_o     : frame counter, increments once per PWM frame
//   frame_tick_c    : combinational, high while pwm_cnt is all-ones
//   frame_o         : registered pulse, high in the cycle pwm_cnt is 0
module gled_timebase #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned BLINK_W  = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic [BLINK_W-1:0]  frame_cnt_o,
  output logic                frame_tick_c,
  output logic                frame_o
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                frame_q, frame_d;

  // Counter advance and frame boundary detection
  always_comb begin
    frame_tick_c = (pwm_cnt_q == {PWM_BITS{1'b1}});
    pwm_cnt_d    = pwm_cnt_q + PWM_BITS'(1);
    frame_cnt_d  = frame_cnt_q;
    frame_d      = 1'b0;
    if (frame_tick_c) begin
      frame_cnt_d = frame_cnt_q + BLINK_W'(1);
      frame_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_cnt_q   <= '0;
      frame_cnt_q <= '0;
      frame_q     <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
    end
  end

  assign pwm_cnt_o   = pwm_cnt_q;
  assign frame_cnt_o = frame_cnt_q;
  assign frame_o     = frame_q;

endmodule

// File: rtl/gled_pwm_ctrl.sv
// Green-LED pin driver: shadows the LED word at PWM frame boundaries and
// applies per-LED enable, blink, global PWM brightness and live bypass.
//   clk_i, rst_ni : clock, async active-low reset
//   gled_word_i   : LED word from the LSU LED buffer (gled_word_t layout)
//   ledg_o        : registered green-LED pins
//   frame_o       : one-cycle pulse in the cycle the shadow register loads
module gled_pwm_ctrl
  import gled_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BLINK_W    = 20,
  parameter int unsigned BLINK_BASE = 14
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [GLED_WORD_W-1:0]   gled_word_i,
  output logic [GLED_NUM_LEDS-1:0] ledg_o,
  output logic                     frame_o
);

  localparam int unsigned IDX_W = (BLINK_W > 1) ? $clog2(BLINK_W) : 1;

  logic [PWM_BITS-1:0]      pwm_cnt;
  logic [BLINK_W-1:0]       frame_cnt;
  logic                     frame_tick_c;

  gled_word_t               word_c;
  gled_word_t               shadow_q, shadow_d;
  logic [GLED_NUM_LEDS-1:0] ledg_q, ledg_d;

  logic [PWM_BITS-1:0]      duty_c;
  logic                     pwm_on_c;
  logic [IDX_W-1:0]         blink_idx_c;
  logic                     blink_phase_c;
  logic                     bypass_c;

  gled_timebase #(
    .PWM_BITS (PWM_BITS),
    .BLINK_W  (BLINK_W)
  ) u_timebase (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pwm_cnt_o    (pwm_cnt),
    .frame_cnt_o  (frame_cnt),
    .frame_tick_c (frame_tick_c),
    .frame_o      (frame_o)
  );

  assign word_c   = gled_word_t'(gled_word_i);
  // Bypass is taken from the live word, never from the shadow
  assign bypass_c = gled_word_i[GLED_BYPASS_BIT];

  // Shadow load, brightness compare, blink gating and pin selection
  always_comb begin
    shadow_d = shadow_q;
    if (frame_tick_c) begin
      shadow_d = word_c;
    end

    duty_c = shadow_q.duty[7 -: PWM_BITS];
    if (duty_c == '0) begin
      pwm_on_c = 1'b0;
    end else if (duty_c == {PWM_BITS{1'b1}}) begin
      // Full scale stays lit through the last counter value too
      pwm_on_c = 1'b1;
    end else begin
      pwm_on_c = (pwm_cnt < duty_c);
    end

    blink_idx_c   = IDX_W'(BLINK_BASE) + IDX_W'(shadow_q.blink_sel);
    blink_phase_c = frame_cnt[blink_idx_c];

    if (bypass_c) begin
      ledg_d = gled_word_i[GLED_ON_LSB +: GLED_NUM_LEDS];
    end else begin
      ledg_d = shadow_q.on & {GLED_NUM_LEDS{pwm_on_c}} &
               (~shadow_q.blink | {GLED_NUM_LEDS{blink_phase_c}});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      ledg_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      ledg_q   <= ledg_d;
    end
  end

  assign ledg_o = ledg_q;

  // Shadowed bypass/reserved bits and duty bits below the PWM resolution have no effect
  logic unused_shadow_c;
  assign unused_shadow_c = ^{shadow_q.bypass, shadow_q.reserved, shadow_q.duty,
                             gled_word_i[GLED_BYPASS_BIT-1:GLED_RSVD_LSB],
                             gled_word_i[GLED_SEL_LSB], gled_word_i[GLED_DUTY_LSB],
                             gled_word_i[GLED_BLINK_LSB]};

endmodule
